// File: rtl/spi_mosi_stream_buffer_pkg.sv
// Shared constants for the streaming SPI MOSI buffer: FSM encoding, FIFO entry layout, defaults.
package spi_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_CS_IDLE = 2;

  // SPI mode 0: SCLK idles low, data sampled by the slave on the rising edge.
  localparam logic SCLK_IDLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_GAP      = 3'd3,
    ST_DESELECT = 3'd4
  } state_t;

  // FIFO entry = {LAST, DC, DATA[width-1:0]}
  localparam int unsigned ENT_DATA_LSB = 0;

  function automatic int unsigned ent_dc_bit(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned ent_last_bit(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/spi_mosi_stream_buffer_if.sv
// Push-side valid/ready handshake carrying one SPI word with its D/C level and frame end flag.
interface spi_mosi_stream_buffer_if
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             dc;
  logic             last;

  modport master (output valid, output data, output dc, output last, input ready);
  modport slave  (input valid, input data, input dc, input last, output ready);
endinterface

// File: rtl/spi_mosi_stream_buffer_sync_fifo.sv
// Synchronous FIFO with fall-through head, extra-MSB pointers for the full test, and a level flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_mosi_stream_buffer.sv
// Streams {D/C, data} words from a FIFO onto an SPI mode-0 link with CS framing per LAST word.
module spi_mosi_stream_buffer
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CS_IDLE = DEF_CS_IDLE
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  spi_mosi_stream_buffer_if.slave   wr,
  input  logic                      i_FLUSH,
  output logic                      o_SCLK,
  output logic                      o_MOSI,
  output logic                      o_DC,
  output logic                      o_CS_N,
  output logic                      o_BUSY,
  output logic [$clog2(DEPTH):0]    o_LEVEL,
  output logic                      o_FRAME_DONE
);
  localparam int unsigned EW       = WIDTH + 2;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW       = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam int unsigned BW       = $clog2(WIDTH);
  localparam int unsigned DC_POS   = ent_dc_bit(WIDTH);
  localparam int unsigned LAST_POS = ent_last_bit(WIDTH);
  localparam logic [BW-1:0] FINAL_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [DW-1:0]    div;
  logic [IW-1:0]    idle_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             cur_last;
  logic [EW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             tick;
  logic             word_end;

  assign wr.ready = !full && !i_FLUSH;
  assign push     = wr.valid && wr.ready;
  assign tick     = (div == DW'(CLK_DIV - 1));
  assign word_end = (state == ST_SHIFT) && tick && o_SCLK && (bit_cnt == FINAL_BIT);
  // Back-to-back words pop on the final falling tick so SCLK runs without a gap.
  assign pop      = !i_FLUSH && !empty &&
                    ((state == ST_IDLE) || (state == ST_GAP) || (word_end && !cur_last));
  assign o_BUSY   = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst   (i_RST),
    .flush (i_FLUSH),
    .push  (push),
    .pop   (pop),
    .din   ({wr.last, wr.dc, wr.data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_LEVEL)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state        <= ST_IDLE;
      div          <= '0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cur_last     <= 1'b0;
      o_SCLK       <= SCLK_IDLE;
      o_MOSI       <= 1'b0;
      o_DC         <= 1'b0;
      o_CS_N       <= 1'b1;
      o_FRAME_DONE <= 1'b0;
    end else if (i_FLUSH) begin
      state        <= ST_IDLE;
      div          <= '0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      o_SCLK       <= SCLK_IDLE;
      o_MOSI       <= 1'b0;
      o_CS_N       <= 1'b1;
      o_FRAME_DONE <= 1'b0;
    end else begin
      o_FRAME_DONE <= 1'b0;
      if (state == ST_IDLE) div <= '0;
      else                  div <= tick ? '0 : div + DW'(1);

      unique case (state)
        ST_IDLE: if (pop) state <= ST_SETUP;
        ST_SETUP: if (tick) begin
          o_SCLK <= 1'b1;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: if (tick) begin
          o_SCLK <= ~o_SCLK;
          if (o_SCLK) begin
            if (bit_cnt != FINAL_BIT) begin
              shreg   <= shreg << 1;
              o_MOSI  <= shreg[WIDTH-2];
              bit_cnt <= bit_cnt + BW'(1);
            end else if (cur_last) begin
              o_CS_N       <= 1'b1;
              o_FRAME_DONE <= 1'b1;
              idle_cnt     <= '0;
              state        <= ST_DESELECT;
            end else if (!pop) begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: if (pop) state <= ST_SETUP;
        ST_DESELECT: if (tick) begin
          if (idle_cnt == IW'(CS_IDLE - 1)) state <= ST_IDLE;
          else                              idle_cnt <= idle_cnt + IW'(1);
        end
        default: state <= ST_IDLE;
      endcase

      // Loading restarts the divider so the SETUP half-period is always full length.
      if (pop) begin
        o_CS_N   <= 1'b0;
        o_DC     <= head[DC_POS];
        o_MOSI   <= head[WIDTH-1];
        shreg    <= head[WIDTH-1:0];
        cur_last <= head[LAST_POS];
        bit_cnt  <= '0;
        div      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_mosi_stream_buffer.sv
// Directed bench for spi_mosi_stream_buffer: framing, streaming, gaps, full FIFO, flush and async reset.
module tb_spi_mosi_stream_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       sclk, mosi, dc, cs_n, busy, frame_done;
  logic [4:0] level;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic        bits[$];
  logic        dcs[$];
  int unsigned rises     = 0;
  int unsigned fd_cnt    = 0;
  int unsigned cs_rises  = 0;
  int unsigned first_rise = 0;
  int unsigned last_rise  = 0;

  spi_mosi_stream_buffer_if #(.WIDTH(8)) wr_if ();

  spi_mosi_stream_buffer #(
    .WIDTH   (8),
    .DEPTH   (16),
    .CLK_DIV (4),
    .CS_IDLE (2)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .wr           (wr_if),
    .i_FLUSH      (flush),
    .o_SCLK       (sclk),
    .o_MOSI       (mosi),
    .o_DC         (dc),
    .o_CS_N       (cs_n),
    .o_BUSY       (busy),
    .o_LEVEL      (level),
    .o_FRAME_DONE (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave-side view of the link: what a mode-0 receiver would latch.
  always @(posedge sclk) begin
    bits.push_back(mosi);
    dcs.push_back(dc);
    rises++;
    if (rises == 1) first_rise = cyc;
    last_rise = cyc;
  end
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;
  always @(posedge cs_n) cs_rises++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_at(input int unsigned w);
    logic [7:0] v = '0;
    for (int unsigned b = 0; b < 8; b++)
      if (w * 8 + b < bits.size()) v = {v[6:0], bits[w*8+b]};
    return v;
  endfunction

  function automatic logic dc_at(input int unsigned w);
    return (w * 8 < dcs.size()) ? dcs[w*8] : 1'bx;
  endfunction

  task automatic clear_mon();
    bits.delete();
    dcs.delete();
    rises    = 0;
    fd_cnt   = 0;
    cs_rises = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic dcv, input logic last);
    int unsigned n = 0;
    @(negedge clk);
    wr_if.valid = 1'b1; wr_if.data = d; wr_if.dc = dcv; wr_if.last = last;
    while (!wr_if.ready && n < 3000) begin @(negedge clk); n++; end
    if (!wr_if.ready) check_eq("push_ready_timeout", 32'(wr_if.ready), 1);
    @(posedge clk);
    #1 wr_if.valid = 1'b0;
  endtask

  task automatic push_raw(input logic [7:0] d, input logic dcv, input logic last);
    @(negedge clk);
    wr_if.valid = 1'b1; wr_if.data = d; wr_if.dc = dcv; wr_if.last = last;
    @(posedge clk);
    #1 wr_if.valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k = 0;
    while ((busy || level != 0 || !cs_n) && k < budget) begin @(negedge clk); k++; end
    check_eq("wait_done", 32'(!busy && level == 0), 1);
  endtask

  task automatic wait_rises(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rises < n && k < budget) begin @(negedge clk); k++; end
    check_eq("wait_rises", 32'(rises >= n), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    int unsigned c0;
    int unsigned fd0;
    logic [7:0]  exp_w;

    rst = 1'b1; flush = 1'b0;
    wr_if.valid = 1'b0; wr_if.data = '0; wr_if.dc = 1'b0; wr_if.last = 1'b0;
    #23;
    check_eq("rst_sclk", 32'(sclk), 0);
    check_eq("rst_mosi", 32'(mosi), 0);
    check_eq("rst_dc", 32'(dc), 0);
    check_eq("rst_cs_n", 32'(cs_n), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_fd", 32'(frame_done), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(wr_if.ready), 1);
    clear_mon();

    // Single word 0xA5, DC=0, LAST
    push(8'hA5, 1'b0, 1'b1);
    k = 0;
    while (cs_n && k < 50) begin @(negedge clk); k++; end
    c0 = cyc;
    k = 0;
    while (!sclk && k < 50) begin @(negedge clk); k++; end
    check_eq("t1_cs_to_sclk", cyc - c0, 4);
    k = 0;
    while (!frame_done && k < 200) begin @(negedge clk); k++; end
    check_eq("t1_fd_cs_n", 32'(cs_n), 1);
    check_eq("t1_fd_sclk", 32'(sclk), 0);
    check_eq("t1_rises", rises, 8);
    check_eq("t1_word", 32'(word_at(0)), 32'h A5);
    check_eq("t1_dc", 32'(dc_at(0)), 0);
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    check_eq("t1_busy_tail", k, 8);
    check_eq("t1_fd_cnt", fd_cnt, 1);
    clear_mon();

    // Three-word frame, streamed without gaps
    push(8'h81, 1'b0, 1'b0);
    push(8'h12, 1'b1, 1'b0);
    push(8'h34, 1'b1, 1'b1);
    wait_done(500);
    check_eq("t2_rises", rises, 24);
    check_eq("t2_contig", last_rise - first_rise, 23 * 8);
    check_eq("t2_cs_rises", cs_rises, 1);
    check_eq("t2_fd_cnt", fd_cnt, 1);
    check_eq("t2_w0", 32'(word_at(0)), 32'h81);
    check_eq("t2_w1", 32'(word_at(1)), 32'h12);
    check_eq("t2_w2", 32'(word_at(2)), 32'h34);
    check_eq("t2_dc0", 32'(dc_at(0)), 0);
    check_eq("t2_dc1", 32'(dc_at(1)), 1);
    check_eq("t2_dc2", 32'(dc_at(2)), 1);
    clear_mon();

    // Underrun gap inside a frame
    push(8'h5A, 1'b1, 1'b0);
    wait_rises(8, 200);
    repeat (50) @(negedge clk);
    check_eq("t3_gap_sclk", 32'(sclk), 0);
    check_eq("t3_gap_cs_n", 32'(cs_n), 0);
    check_eq("t3_gap_busy", 32'(busy), 1);
    check_eq("t3_gap_fd", fd_cnt, 0);
    push(8'hC3, 1'b0, 1'b1);
    k = 0;
    while (!sclk && k < 50) begin @(negedge clk); k++; end
    check_eq("t3_setup_lat", k, 6);
    wait_done(500);
    check_eq("t3_rises", rises, 16);
    check_eq("t3_w0", 32'(word_at(0)), 32'h5A);
    check_eq("t3_w1", 32'(word_at(1)), 32'hC3);
    check_eq("t3_dc1", 32'(dc_at(1)), 0);
    check_eq("t3_fd_cnt", fd_cnt, 1);
    check_eq("t3_cs_rises", cs_rises, 1);
    clear_mon();

    // Fill to DEPTH while the first word is still shifting; two extra pushes must drop
    push(8'h42, 1'b0, 1'b0);
    wait_rises(1, 50);
    for (int unsigned i = 0; i < 16; i++) push_raw(8'h10 + 8'(i), i[0], (i == 15));
    check_eq("t4_level_full", 32'(level), 16);
    check_eq("t4_ready_full", 32'(wr_if.ready), 0);
    push_raw(8'hEE, 1'b0, 1'b1);
    push_raw(8'hEF, 1'b1, 1'b1);
    check_eq("t4_level_hold", 32'(level), 16);
    wait_done(3000);
    check_eq("t4_words", 32'(bits.size() / 8), 17);
    check_eq("t4_w0", 32'(word_at(0)), 32'h42);
    for (int unsigned i = 0; i < 16; i++) begin
      exp_w = 8'h10 + 8'(i);
      check_eq($sformatf("t4_w%0d", i + 1), 32'(word_at(i + 1)), 32'(exp_w));
      check_eq($sformatf("t4_dc%0d", i + 1), 32'(dc_at(i + 1)), 32'(i[0]));
    end
    check_eq("t4_fd_cnt", fd_cnt, 1);
    clear_mon();

    // Flush mid-bit-3 with 5 words queued and a simultaneous push
    push(8'hF0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1, 1'b0);
    check_eq("t5_level_pre", 32'(level), 5);
    wait_rises(4, 100);
    fd0 = fd_cnt;
    @(negedge clk);
    check_eq("t5_pre_sclk", 32'(sclk), 1);
    flush = 1'b1;
    wr_if.valid = 1'b1; wr_if.data = 8'h77; wr_if.dc = 1'b0; wr_if.last = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_cs_n", 32'(cs_n), 1);
    check_eq("t5_sclk", 32'(sclk), 0);
    check_eq("t5_mosi", 32'(mosi), 0);
    check_eq("t5_level", 32'(level), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_ready", 32'(wr_if.ready), 0);
    flush = 1'b0;
    wr_if.valid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t5_level_after", 32'(level), 0);
    check_eq("t5_busy_after", 32'(busy), 0);
    check_eq("t5_no_fd", fd_cnt, fd0);
    check_eq("t5_no_rises", rises, 4);
    clear_mon();

    // Asynchronous reset during SHIFT, then a fresh frame
    push(8'h3C, 1'b1, 1'b1);
    wait_rises(3, 100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_sclk", 32'(sclk), 0);
    check_eq("t6_mosi", 32'(mosi), 0);
    check_eq("t6_dc", 32'(dc), 0);
    check_eq("t6_cs_n", 32'(cs_n), 1);
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_level", 32'(level), 0);
    check_eq("t6_fd", 32'(frame_done), 0);
    @(negedge clk); rst = 1'b0;
    clear_mon();
    push(8'h96, 1'b1, 1'b1);
    wait_done(500);
    check_eq("t6_rises", rises, 8);
    check_eq("t6_word", 32'(word_at(0)), 32'h96);
    check_eq("t6_dc_word", 32'(dc_at(0)), 1);
    check_eq("t6_fd_cnt", fd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
